mem_arbiter_rr: RTL

//  Parametrised N-CPU arbiter between per-CPU instruction/data request ports and the single RAM port.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_rr_picker.sv | 28 ++
 rtl/mem_arbiter_rr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state and the machine word.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int IDX_W = 8;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    typedef struct packed {
        logic             valid;
        logic             is_data;
        logic [IDX_W-1:0] idx;
    } owner_t;

    function automatic int arb_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, wrapping around.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate down so the closest one to ptr_i wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-CPU instruction/data arbiter onto a single RAM port, per-class round-robin.
// Optional instruction anti-starvation enabled by defining MEM_ARB_ISTARVE_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate and drive RAM from the winner this cycle
// HOLD  | owner registered; only the owner drives RAM until ACCESS or abort
module mem_arbiter_rr
    import cpu_types_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ISTARVE_MAX = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0][AW-1:0]  iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0][DW-1:0]  iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][AW-1:0]  daddr,
    input  logic [CPUS-1:0][DW-1:0]  dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0][DW-1:0]  dload,
    input  ramstate_t                ramstate,
    input  logic [DW-1:0]            ramload,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    output logic                     ramREN,
    output logic                     ramWEN
);

    localparam int IW = arb_iw(CPUS);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [IW-1:0] iptr_q, iptr_d, dptr_q, dptr_d;

    logic [CPUS-1:0] dreq;
    logic [IW-1:0]   igrant_idx, dgrant_idx, sgrant_idx;
    logic            igrant_vld, dgrant_vld, sgrant_vld;
    logic            act_valid, act_data, done;
    logic [IW-1:0]   act_idx;
    logic            unused_idx_bits;

    assign dreq            = dREN | dWEN;
    assign unused_idx_bits = ^owner_q.idx;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(CPUS - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_picker #(.N(CPUS), .IW(IW)) u_pick_i (
        .req_i(iREN), .ptr_i(iptr_q), .gnt_idx_o(igrant_idx), .gnt_valid_o(igrant_vld)
    );

    rr_picker #(.N(CPUS), .IW(IW)) u_pick_d (
        .req_i(dreq), .ptr_i(dptr_q), .gnt_idx_o(dgrant_idx), .gnt_valid_o(dgrant_vld)
    );

`ifdef MEM_ARB_ISTARVE_EN
    localparam int SW = $clog2(ISTARVE_MAX + 1);

    logic [CPUS-1:0][SW-1:0] scnt_q, scnt_d;
    logic [CPUS-1:0]         starved;

    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            starved[i] = iREN[i] && (scnt_q[i] >= SW'(ISTARVE_MAX));
        end
    end

    rr_picker #(.N(CPUS), .IW(IW)) u_pick_s (
        .req_i(starved), .ptr_i(iptr_q), .gnt_idx_o(sgrant_idx), .gnt_valid_o(sgrant_vld)
    );

    // A pending instruction request ages once per data completion; saturates at the threshold.
    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            scnt_d[i] = scnt_q[i];
            if (!iREN[i] || (done && !act_data && act_idx == IW'(i))) begin
                scnt_d[i] = '0;
            end else if (done && act_data && scnt_q[i] < SW'(ISTARVE_MAX)) begin
                scnt_d[i] = scnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) scnt_q <= '0;
        else       scnt_q <= scnt_d;
    end
`else
    logic unused_starve_cfg;

    assign sgrant_vld        = 1'b0;
    assign sgrant_idx        = '0;
    assign unused_starve_cfg = (ISTARVE_MAX == 0);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            iptr_q  <= '0;
            dptr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            iptr_q  <= iptr_d;
            dptr_q  <= dptr_d;
        end
    end

    always_comb begin
        act_valid = 1'b0;
        act_data  = 1'b0;
        act_idx   = '0;
        if (state_q == IDLE) begin
            if (sgrant_vld) begin
                act_valid = 1'b1;
                act_idx   = sgrant_idx;
            end else if (dgrant_vld) begin
                act_valid = 1'b1;
                act_data  = 1'b1;
                act_idx   = dgrant_idx;
            end else if (igrant_vld) begin
                act_valid = 1'b1;
                act_idx   = igrant_idx;
            end
        end else if (owner_q.valid) begin
            // A HOLD owner that has dropped its request is an abort.
            act_data  = owner_q.is_data;
            act_idx   = owner_q.idx[IW-1:0];
            act_valid = owner_q.is_data ? dreq[act_idx] : iREN[act_idx];
        end
        done = act_valid && (ramstate == ACCESS);

        state_d = state_q;
        owner_d = owner_q;
        iptr_d  = iptr_q;
        dptr_d  = dptr_q;
        if (done) begin
            state_d = IDLE;
            owner_d = '0;
            if (act_data) dptr_d = next_ptr(act_idx);
            else          iptr_d = next_ptr(act_idx);
        end else if (act_valid) begin
            state_d = HOLD;
            owner_d = '{valid: 1'b1, is_data: act_data, idx: IDX_W'(act_idx)};
        end else begin
            state_d = IDLE;
            owner_d = '0;
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        if (nRST && act_valid) begin
            if (act_data) begin
                ramaddr = daddr[act_idx];
                if (dWEN[act_idx]) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore[act_idx];
                end else begin
                    ramREN = 1'b1;
                end
                if (done) begin
                    dwait[act_idx] = 1'b0;
                    dload[act_idx] = ramload;
                end
            end else begin
                ramaddr = iaddr[act_idx];
                ramREN  = iREN[act_idx];
                if (done) begin
                    iwait[act_idx] = 1'b0;
                    iload[act_idx] = ramload;
                end
            end
        end
    end

endmodule
